// File: rtl/firmware_loader.sv
// firmware_loader: receives a framed byte stream (addr, len, payload, checksum)
// and writes the payload into the firmware RAM, holding the CPU in reset until
// a load with a legal range and a zero-sum checksum has completed.
module firmware_loader #(
  parameter int SIZE   = 'h3000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              cpu_hold
);

  typedef enum logic [3:0] {
    S_IDLE, S_H0, S_H1, S_H2, S_H3, S_CHECK, S_DATA, S_SUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_RANGE = 2'd1;
  localparam logic [1:0] E_SUM   = 2'd2;

  state_t              r_state;
  logic [15:0]         r_addr;
  logic [15:0]         r_len;
  logic [15:0]         r_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [7:0]          r_sum;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_mem_we;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic                r_cpu_hold;

  logic                w_ready;
  logic                w_accept;
  logic [7:0]          w_sum_next;
  logic [16:0]         w_end;
  logic                w_range_bad;

  // Byte acceptance is a pure decode of the state so the stream never sees a
  // ready that depends on in_valid.
  assign w_ready = (r_state == S_H0) || (r_state == S_H1) ||
                   (r_state == S_H2) || (r_state == S_H3) ||
                   (r_state == S_DATA) || (r_state == S_SUM);
  assign w_accept   = in_valid & w_ready;
  assign w_sum_next = r_sum + in_data;

  // 17-bit end address so addr+len cannot overflow before the compare;
  // the addr>=SIZE test also rejects any set bit above ADDR_W.
  assign w_end       = {1'b0, r_addr} + {1'b0, r_len};
  assign w_range_bad = (r_len == 16'd0) ||
                       ({1'b0, r_addr} >= 17'(SIZE)) ||
                       (w_end > 17'(SIZE));

  // Load sequencer: header capture, range check, payload writes, checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_sum       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= E_NONE;
      r_cpu_hold  <= 1'b1;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state    <= S_H0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
            r_sum      <= '0;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
          end
        end
        S_H0: begin
          if (w_accept) begin
            r_addr[7:0] <= in_data;
            r_sum       <= w_sum_next;
            r_state     <= S_H1;
          end
        end
        S_H1: begin
          if (w_accept) begin
            r_addr[15:8] <= in_data;
            r_sum        <= w_sum_next;
            r_state      <= S_H2;
          end
        end
        S_H2: begin
          if (w_accept) begin
            r_len[7:0] <= in_data;
            r_sum      <= w_sum_next;
            r_state    <= S_H3;
          end
        end
        S_H3: begin
          if (w_accept) begin
            r_len[15:8] <= in_data;
            r_sum       <= w_sum_next;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_range_bad) begin
            r_state    <= S_ERROR;
            r_err      <= 1'b1;
            r_err_code <= E_RANGE;
            r_busy     <= 1'b0;
          end else begin
            r_state <= S_DATA;
            r_ptr   <= r_addr[ADDR_W-1:0];
            r_cnt   <= r_len;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= in_data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_cnt       <= r_cnt - 16'd1;
            r_sum       <= w_sum_next;
            if (r_cnt == 16'd1) r_state <= S_SUM;
          end
        end
        S_SUM: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (w_sum_next == 8'd0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state    <= S_ERROR;
              r_err      <= 1'b1;
              r_err_code <= E_SUM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign cpu_hold  = r_cpu_hold;

endmodule

// File: tb/tb_firmware_loader.sv
// Bench for firmware_loader: drives frames (fixed and random, with random
// in_valid gaps) and compares RAM writes and final status with a frame-level
// reference model.
module tb_firmware_loader;
  localparam int SIZE   = 'h3000;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              busy, done, err, cpu_hold;
  logic [1:0]        err_code;

  firmware_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         wr_addr[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         acc_cyc[$];
  int         nr_cnt;
  bit         tmo;

  logic [7:0] frame[$];
  int         exp_addr[$];
  logic [7:0] exp_data[$];
  logic       exp_done;
  logic [1:0] exp_code;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes, accepted bytes and busy-but-not-ready cycles mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (busy && !in_ready) nr_cnt++;
  end

  // Frame-level reference: what a loader must do with the bytes in 'frame'.
  task automatic model();
    int a, l, s;
    a = int'(frame[0]) | (int'(frame[1]) << 8);
    l = int'(frame[2]) | (int'(frame[3]) << 8);
    exp_addr.delete();
    exp_data.delete();
    if (l == 0 || a >= SIZE || a + l > SIZE) begin
      exp_code = 2'd1;
      exp_done = 1'b0;
    end else begin
      s = 0;
      for (int i = 0; i < l; i++) begin
        exp_addr.push_back(a + i);
        exp_data.push_back(frame[4 + i]);
      end
      for (int i = 0; i < 5 + l; i++) s += int'(frame[i]);
      exp_code = ((s % 256) == 0) ? 2'd0 : 2'd2;
      exp_done = (exp_code == 2'd0);
    end
  endtask

  // Pulse start, stream 'frame' honouring in_ready, optionally with random
  // in_valid gaps and a stray start pulse while byte index pulse_at is offered.
  task automatic run_frame(input bit gaps, input int pulse_at, input bit settle);
    int idx, budget;
    bit pulsed;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
    nr_cnt = 0; tmo = 1'b0;
    idx = 0; budget = 0; pulsed = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (1) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = frame[idx];
      if (idx == pulse_at && !pulsed) begin start = 1'b1; pulsed = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (idx >= frame.size() || !busy) break;
      budget++;
      if (budget > 3000) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 in_valid = 1'b0; start = 1'b0;
    if (settle) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      model();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, cpu_hold} !==
        {1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL reset.values got rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b c=%0d h=%b want 0 0 0 0 0 0 0 0 1",
        in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, cpu_hold);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, busy, cpu_hold, mem_we} !== 4'b0010) begin
      bad++; $display("FAIL reset.idle got rdy=%b busy=%b hold=%b we=%b want 0 0 1 0", in_ready, busy, cpu_hold, mem_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_good();
    frame = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
    run_frame(1'b0, -1, 1'b1);
    total++; if (tmo) begin bad++; $display("FAIL good.timeout got=1 want=0"); end
    total++;
    if (wr_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL good.count got=%0d want=%0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL good.write%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
      total++;
      if (4 + i >= acc_cyc.size() || wr_cyc[i] !== acc_cyc[4 + i] + 1) begin
        bad++; $display("FAIL good.latency%0d got=%0d want=%0d", i, wr_cyc[i], acc_cyc[4 + i] + 1);
      end
    end
    total++;
    if ({busy, done, err, err_code, cpu_hold} !== {1'b0, 1'b1, 1'b0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL good.status got b=%b d=%b e=%b c=%0d h=%b want 0 1 0 0 0", busy, done, err, err_code, cpu_hold);
    end
  endtask

  task automatic test_boundary();
    frame = '{8'hFF, 8'h2F, 8'h01, 8'h00, 8'h5A, 8'h77};
    run_frame(1'b0, -1, 1'b1);
    total++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 'h2FFF || wr_data[0] !== 8'h5A) begin
      bad++; $display("FAIL boundary.write got n=%0d %h:%h want n=1 2fff:5a", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    total++;
    if ({done, err, cpu_hold} !== {exp_done, !exp_done, !exp_done} || exp_done !== 1'b1) begin
      bad++; $display("FAIL boundary.done got d=%b e=%b h=%b want 1 0 0", done, err, cpu_hold);
    end
    frame = '{8'hFF, 8'h2F, 8'h02, 8'h00, 8'h5A, 8'h5B, 8'h00};
    run_frame(1'b0, -1, 1'b1);
    total++;
    if (wr_addr.size() != 0 || acc_cyc.size() != 4) begin
      bad++; $display("FAIL boundary.over_writes got writes=%0d accepts=%0d want 0 4", wr_addr.size(), acc_cyc.size());
    end
    total++;
    if ({done, err, err_code, cpu_hold} !== {1'b0, 1'b1, exp_code, 1'b1}) begin
      bad++; $display("FAIL boundary.over_status got d=%b e=%b c=%0d h=%b want 0 1 %0d 1", done, err, err_code, cpu_hold, exp_code);
    end
  endtask

  task automatic test_zero_len();
    int rdy_seen;
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    run_frame(1'b0, -1, 1'b1);
    total++;
    if (err_code !== 2'd1 || err !== 1'b1 || wr_addr.size() != 0 || acc_cyc.size() != 4) begin
      bad++; $display("FAIL zero_len.status got c=%0d e=%b writes=%0d accepts=%0d want 1 1 0 4",
        err_code, err, wr_addr.size(), acc_cyc.size());
    end
    rdy_seen = 0;
    in_valid = 1'b1; in_data = 8'h33;
    repeat (5) begin @(negedge clk); if (in_ready) rdy_seen++; end
    in_valid = 1'b0;
    total++;
    if (rdy_seen != 0) begin bad++; $display("FAIL zero_len.ready got=%0d want=0", rdy_seen); end
  endtask

  task automatic test_bad_sum();
    frame = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hCA};
    run_frame(1'b0, -1, 1'b1);
    total++;
    if (wr_addr.size() != 3) begin bad++; $display("FAIL bad_sum.count got=%0d want=3", wr_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL bad_sum.write%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    total++;
    if ({done, err, err_code, cpu_hold} !== {1'b0, 1'b1, 2'd2, 1'b1} || exp_code !== 2'd2) begin
      bad++; $display("FAIL bad_sum.status got d=%b e=%b c=%0d h=%b want 0 1 2 1", done, err, err_code, cpu_hold);
    end
  endtask

  task automatic test_gaps();
    frame = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
    run_frame(1'b1, 6, 1'b1);
    total++; if (tmo) begin bad++; $display("FAIL gaps.timeout got=1 want=0"); end
    total++;
    if (wr_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL gaps.count got=%0d want=%0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL gaps.write%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
      total++;
      if (4 + i >= acc_cyc.size() || wr_cyc[i] !== acc_cyc[4 + i] + 1) begin
        bad++; $display("FAIL gaps.latency%0d got=%0d want=%0d", i, wr_cyc[i], acc_cyc[4 + i] + 1);
      end
    end
    total++;
    if (nr_cnt != 1) begin bad++; $display("FAIL gaps.check_cycle got=%0d want=1", nr_cnt); end
    total++;
    if ({busy, done, err, cpu_hold} !== 4'b0100) begin
      bad++; $display("FAIL gaps.status got b=%b d=%b e=%b h=%b want 0 1 0 0", busy, done, err, cpu_hold);
    end
  endtask

  task automatic test_reset_mid_data();
    frame = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB};
    run_frame(1'b0, -1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, cpu_hold} !==
        {1'b0, 1'b0, 14'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL mid_reset.values got rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b c=%0d h=%b want 0 0 0 0 0 0 0 0 1",
        in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, cpu_hold);
    end
    in_valid = 1'b1; in_data = 8'hCC;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 'h100 || wr_data[0] !== 8'hAA) begin
      bad++; $display("FAIL mid_reset.writes got n=%0d first=%h:%h want n=1 100:aa", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    rst_n = 1'b1;
    frame = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hCB};
    run_frame(1'b0, -1, 1'b1);
    total++;
    if (wr_addr.size() != 3 || wr_addr[2] !== exp_addr[2] || wr_data[2] !== exp_data[2]) begin
      bad++; $display("FAIL mid_reset.reload_writes got n=%0d last=%h:%h want n=3 %h:%h",
        wr_addr.size(), wr_addr[2], wr_data[2], exp_addr[2], exp_data[2]);
    end
    total++;
    if ({busy, done, err, cpu_hold} !== 4'b0100) begin
      bad++; $display("FAIL mid_reset.reload_status got b=%b d=%b e=%b h=%b want 0 1 0 0", busy, done, err, cpu_hold);
    end
  endtask

  task automatic test_random();
    int a, l, s;
    logic [7:0] b, cs;
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0:       a = SIZE - $urandom_range(0, 6);
        1:       a = $urandom_range(0, SIZE - 1) | 'h4000;
        default: a = $urandom_range(0, SIZE - 1);
      endcase
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      frame.delete();
      frame.push_back(a[7:0]); frame.push_back(a[15:8]);
      frame.push_back(l[7:0]); frame.push_back(l[15:8]);
      s = a[7:0] + a[15:8] + l[7:0] + l[15:8];
      for (int i = 0; i < l; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        s += int'(b);
      end
      cs = 8'(0 - s);
      if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
      frame.push_back(cs);
      run_frame(1'b1, -1, 1'b1);
      total++;
      if (tmo || wr_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL random%0d.count got=%0d want=%0d tmo=%b", n, wr_addr.size(), exp_addr.size(), tmo);
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
        total++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL random%0d.write%0d got=%h:%h want=%h:%h", n, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        end
      end
      total++;
      if ({busy, done, err, err_code, cpu_hold} !== {1'b0, exp_done, !exp_done, exp_code, !exp_done} || nr_cnt != 1) begin
        bad++; $display("FAIL random%0d.status got b=%b d=%b e=%b c=%0d h=%b chk=%0d want 0 %b %b %0d %b 1",
          n, busy, done, err, err_code, cpu_hold, nr_cnt, exp_done, !exp_done, exp_code, !exp_done);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_good();
    test_boundary();
    test_zero_len();
    test_bad_sum();
    test_gaps();
    test_reset_mid_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/firmware_loader.md
Name: firmware_loader

Overview:
- Writer side of the firmware store: receives a framed byte stream (valid/ready) and writes the payload into the 0x3000-byte firmware RAM through a single write port.
- Sits between the host-link byte receiver and the firmware RAM write port.
- Holds the 6502 in reset for the whole load.
- Releases the CPU only when the frame's range and checksum are good.

Parameters:
- SIZE, 'h3000, firmware memory depth in bytes.
- ADDR_W, 14, write address width (= $clog2(SIZE)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that arms a load; ignored unless the FSM is in IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_W  firmware RAM write address.
- mem_wdata  out  8  firmware RAM write data.
- mem_we  out  1  firmware RAM write strobe, one cycle per byte.
- busy  out  1  load in progress.
- done  out  1  last load completed good.
- err  out  1  last load failed.
- err_code  out  2  0 none, 1 range, 2 checksum.
- cpu_hold  out  1  hold CPU in reset.

Behaviour:
- Frame format, in order:
  - addr_lo, addr_hi (start address, 16 bits; bits above ADDR_W must be 0).
  - len_lo, len_hi (byte count, 16 bits).
  - len payload bytes.
  - one checksum byte.
- A byte transfers on a rising edge when in_valid & in_ready.
- Checksum rule: the 8-bit wrapping sum of all header, payload and checksum bytes must equal 0x00.
- FSM states: IDLE, H0, H1, H2, H3, CHECK, DATA, SUM, DONE, ERROR.
  - IDLE / DONE / ERROR: start -> H0; clears done, err, err_code and the running sum.
  - H0..H3: each accepted byte is latched and added to the sum, then the FSM advances to the next state; H3 -> CHECK.
  - CHECK: in_ready=0 for exactly one cycle.
    - Range is computed in 17-bit arithmetic: bad if len==0, or addr>=SIZE, or addr+len>SIZE.
    - Bad range -> ERROR with err_code=1.
    - Good range -> DATA; write pointer = addr, remaining count = len.
  - DATA: each accepted byte:
    - registers mem_wdata=byte and mem_addr=pointer, with mem_we=1 on the next cycle (latency 1);
    - increments the pointer, decrements the count, adds the byte to the sum.
    - When the count reaches 0 after an accept -> SUM.
  - SUM: accept one byte. Sum+byte==0 -> DONE, else ERROR with err_code=2.
  - DONE: done=1, cpu_hold=0, busy=0.
  - ERROR: err=1, cpu_hold stays 1, busy=0.
- in_ready=1 only in H0..H3, DATA and SUM.
- in_valid gaps of any length are tolerated in every state; no byte is lost or duplicated.
- The pointer never wraps: the range check guarantees the last write lands at addr+len-1 <= SIZE-1.
- A failed checksum leaves the RAM already written; the failure is reported only by err.
- start while busy is ignored.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=0, cpu_hold=1.
  - After reset nothing runs until a good load completes.
- Reset asserted mid-load: immediate return to the reset values. No write is issued after the asynchronous assertion. Partially written RAM contents are undefined.

Test Plan:
- Good frame: start, then 00 01 03 00 AA BB CC CB.
  - Required: writes 0x0100=AA, 0x0101=BB, 0x0102=CC, each mem_we one cycle after its accept; no other writes.
  - End state: done=1, err=0, cpu_hold=0.
- Upper boundary: addr 0x2FFF len 1 (FF 2F 01 00 5A, correct checksum).
  - Required: a single write of 0x5A to 0x2FFF, then done=1.
  - Same header with len 2: err=1, err_code=1, zero writes, cpu_hold=1.
- Zero length: header 00 00 00 00 -> err_code=1 after CHECK; in_ready=0 from then on.
- Bad checksum: good frame with last byte CA.
  - Required: all three writes still occur; then err=1, err_code=2, done=0, cpu_hold=1.
- Backpressure/gaps: good frame with in_valid toggled randomly at 50%.
  - Required: identical write sequence; in_ready=0 during the CHECK cycle.
  - start pulsed mid-DATA has no effect.
- Reset mid-DATA: assert rst_n=0 after 2 payload bytes.
  - Required: outputs immediately return to reset values; no further mem_we.
  - A fresh start and good frame then complete normally.
